imem_fetch_ctrl: RTL and testbench

Controller that sequences the byte-addressed, big-endian instruction memory of the pipeline. It owns the PC, drives the memory address, and fills the IF/ID register under stall and redirect control from the hazard and branch logic. Before execution, it accepts 32-bit words from a loader port and serialises each one into four byte writes. It sits between the instruction memory and the IF/ID stage; the memory itself remains a separate block.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_byte_writer.sv | 61 ++++++
 rtl/imem_fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch controller:
// FSM state encoding, default widths and the NOP encoding.
package imem_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RUN  = 2'd2,
    S_END  = 2'd3
  } state_e;

endpackage

// File: rtl/imem_byte_writer.sv
// Serialises one latched big-endian word into four byte writes, most
// significant byte first. start_i is honoured only while idle.
module imem_byte_writer
  import imem_pkg::*;
#(
  parameter int WORD = WORD_W,
  parameter int BYTE = BYTE_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [WORD-1:0] word_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [1:0]      bidx_o,
  output logic            we_o,
  output logic [BYTE-1:0] wdata_o
);

  logic [WORD-1:0] word_q;
  logic [1:0]      bidx_q;
  logic            busy_q;
  logic [BYTE-1:0] byte_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      bidx_q <= 2'd0;
      busy_q <= 1'b0;
    end else if (!busy_q) begin
      if (start_i) begin
        word_q <= word_i;
        bidx_q <= 2'd0;
        busy_q <= 1'b1;
      end
    end else begin
      bidx_q <= bidx_q + 2'd1;
      if (bidx_q == 2'd3) begin
        busy_q <= 1'b0;
      end
    end
  end

  always_comb begin
    byte_sel = '0;
    case (bidx_q)
      2'd0: byte_sel = word_q[WORD-1          -: BYTE];
      2'd1: byte_sel = word_q[WORD-1 - BYTE   -: BYTE];
      2'd2: byte_sel = word_q[WORD-1 - 2*BYTE -: BYTE];
      2'd3: byte_sel = word_q[WORD-1 - 3*BYTE -: BYTE];
      default: byte_sel = '0;
    endcase
  end

  assign busy_o  = busy_q;
  assign done_o  = busy_q && (bidx_q == 2'd3);
  assign bidx_o  = bidx_q;
  assign we_o    = busy_q;
  assign wdata_o = busy_q ? byte_sel : '0;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: loads the byte-wide instruction memory from
// the loader port, then fetches into IF/ID under stall/redirect control.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int WORD     = WORD_W,
  parameter int BYTE     = BYTE_W,
  parameter int LINE     = 42,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            ld_valid,
  input  logic [WORD-1:0] ld_word,
  output logic            ld_ready,
  output logic [WORD-1:0] mem_addr,
  output logic [BYTE-1:0] mem_wdata,
  output logic            mem_we,
  input  logic [WORD-1:0] mem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_pc,
  output logic [WORD-1:0] pc,
  output logic [WORD-1:0] if_id_instr,
  output logic [WORD-1:0] if_id_pc4,
  output logic            if_id_valid,
  output logic            fetch_end,
  output state_e          state_dbg
);

  localparam logic [WORD-1:0] MEM_BYTES = WORD'(4 * LINE);
  localparam logic [WORD-1:0] PC_RST    = WORD'(RESET_PC);

  state_e          state_q;
  logic [WORD-1:0] pc_q;
  logic [WORD-1:0] instr_q;
  logic [WORD-1:0] pc4_q;
  logic            valid_q;
  logic [WORD-1:0] lptr_q;

  logic            wr_start;
  logic            wr_busy;
  logic            wr_done;
  logic [1:0]      wr_bidx;
  logic [WORD-1:0] pc_plus4;
  logic [WORD-1:0] lptr_next;
  logic [WORD-1:0] redir_tgt;

  assign wr_start  = (state_q == S_IDLE) && ld_valid;
  assign pc_plus4  = pc_q + WORD'(4);
  assign lptr_next = ((lptr_q + WORD'(4)) == MEM_BYTES) ? '0 : lptr_q + WORD'(4);
  // Redirect targets are word-aligned by discarding the byte offset.
  assign redir_tgt = {redirect_pc[WORD-1:2], 2'b00};

  imem_byte_writer #(
    .WORD (WORD),
    .BYTE (BYTE)
  ) u_writer (
    .clk     (clk),
    .reset   (reset),
    .start_i (wr_start),
    .word_i  (ld_word),
    .busy_o  (wr_busy),
    .done_o  (wr_done),
    .bidx_o  (wr_bidx),
    .we_o    (mem_we),
    .wdata_o (mem_wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RST;
      instr_q <= NOP;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      lptr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ld_valid) begin
            state_q <= S_WR;
          end else if (start) begin
            state_q <= S_RUN;
            pc_q    <= PC_RST;
          end
        end
        S_WR: begin
          if (wr_done) begin
            lptr_q  <= lptr_next;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          if (redirect) begin
            pc_q    <= redir_tgt;
            instr_q <= NOP;
            valid_q <= 1'b0;
          end else if (!stall) begin
            instr_q <= mem_rdata;
            pc4_q   <= pc_plus4;
            valid_q <= 1'b1;
            pc_q    <= pc_plus4;
            if (pc_plus4 >= MEM_BYTES) begin
              state_q <= S_END;
            end
          end
        end
        S_END: begin
          if (redirect) begin
            pc_q    <= redir_tgt;
            instr_q <= NOP;
            valid_q <= 1'b0;
            state_q <= (redir_tgt < MEM_BYTES) ? S_RUN : S_END;
          end else if (!stall) begin
            instr_q <= NOP;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The writer is only ever busy while the FSM sits in WR.
  assign mem_addr    = (state_q == S_WR && wr_busy) ? lptr_q + WORD'(wr_bidx) : pc_q;
  assign ld_ready    = (state_q == S_IDLE);
  assign fetch_end   = (state_q == S_END);
  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: behavioural memory image plus a reference model
// of loading and fetching, compared against the DUT at every negative edge.
module tb_imem_fetch_ctrl;
  import imem_pkg::*;

  localparam int LINE = 42;
  localparam int MEMB = 4 * LINE;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset, start, ld_valid, stall, redirect;
  logic [31:0] ld_word, redirect_pc, mem_rdata;
  logic        ld_ready, mem_we, if_id_valid, fetch_end;
  logic [31:0] mem_addr, pc, if_id_instr, if_id_pc4;
  logic [7:0]  mem_wdata;
  state_e      dbg_state;

  int compared   = 0;
  int mismatched = 0;

  // clock / reset block
  always #5 clk = ~clk;

  imem_fetch_ctrl #(.LINE(LINE), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid),
    .ld_word(ld_word), .ld_ready(ld_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .fetch_end(fetch_end), .state_dbg(dbg_state)
  );

  // Instruction memory block: written by the DUT, read combinationally.
  logic [7:0] mem_arr [0:MEMB-1];
  always @(posedge clk) begin
    if (mem_we && mem_addr < MEMB) mem_arr[mem_addr] <= mem_wdata;
  end
  always_comb begin
    mem_rdata = '0;
    if (mem_addr < MEMB - 3)
      mem_rdata = {mem_arr[mem_addr], mem_arr[mem_addr+1], mem_arr[mem_addr+2], mem_arr[mem_addr+3]};
  end

  // Reference model: expected memory image, pending byte writes and fetch state.
  typedef enum int {M_IDLE, M_RUN, M_END} mmode_e;
  logic [7:0]  img [0:MEMB-1];
  logic [39:0] exp_q[$];
  mmode_e      m_mode;
  logic [31:0] m_pc, m_instr, m_pc4, m_lptr;
  logic        m_valid;
  bit          known = 0;

  function automatic logic [31:0] img_word(input logic [31:0] a);
    if (a < MEMB - 3) return {img[a], img[a+1], img[a+2], img[a+3]};
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit wr;
    wr = (exp_q.size() != 0);
    chk("ld_ready", 32'(ld_ready), 32'(!wr && m_mode == M_IDLE));
    chk("mem_we", 32'(mem_we), 32'(wr));
    chk("mem_addr", mem_addr, wr ? exp_q[0][39:8] : m_pc);
    chk("mem_wdata", 32'(mem_wdata), wr ? 32'(exp_q[0][7:0]) : 32'h0);
    chk("pc", pc, m_pc);
    chk("if_id_instr", if_id_instr, m_instr);
    chk("if_id_pc4", if_id_pc4, m_pc4);
    chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
    chk("fetch_end", 32'(fetch_end), 32'(m_mode == M_END));
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    tgt = {redirect_pc[31:2], 2'b00};
    if (reset) begin
      known = 1;
      exp_q.delete();
      m_mode = M_IDLE; m_pc = RST_PC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_lptr = 0;
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (ld_valid) begin
            for (int i = 0; i < 4; i++) begin
              exp_q.push_back({m_lptr + 32'(i), ld_word[31-8*i -: 8]});
              img[m_lptr + 32'(i)] = ld_word[31-8*i -: 8];
            end
            m_lptr = (m_lptr + 4 == MEMB) ? 0 : m_lptr + 4;
          end else if (start) begin
            m_mode = M_RUN; m_pc = RST_PC;
          end
        end
        M_RUN: begin
          if (redirect) begin
            m_pc = tgt; m_instr = 0; m_valid = 0;
          end else if (!stall) begin
            m_instr = img_word(m_pc); m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
            if (m_pc >= MEMB) m_mode = M_END;
          end
        end
        default: begin
          if (redirect) begin
            m_pc = tgt; m_instr = 0; m_valid = 0;
            m_mode = (tgt < MEMB) ? M_RUN : M_END;
          end else if (!stall) begin
            m_instr = 0; m_valid = 0;
          end
        end
      endcase
    end
  endtask

  // driver tasks
  task automatic cyc(input logic lv, input logic [31:0] lw, input logic st,
                     input logic stl, input logic rd, input logic [31:0] rpc,
                     input logic rst);
    @(negedge clk);
    if (known) check_outputs();
    ld_valid = lv; ld_word = lw; start = st; stall = stl;
    redirect = rd; redirect_pc = rpc; reset = rst;
    model_step();
  endtask

  task automatic idle_cyc();
    cyc(0, $urandom, 0, 0, 0, 0, 0);
  endtask

  task automatic do_load(input logic [31:0] w);
    cyc(1, w, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, $urandom, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < MEMB; i++) begin mem_arr[i] = 8'h00; img[i] = 8'h00; end
    reset = 1; start = 0; ld_valid = 0; ld_word = 0; stall = 0; redirect = 0; redirect_pc = 0;
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle_cyc();
    chk("reset_pc", pc, 32'h0);
    chk("reset_ld_ready", 32'(ld_ready), 32'h1);

    do_load(32'h2008_0020);
    idle_cyc();
    chk("first_word_image", {mem_arr[0], mem_arr[1], mem_arr[2], mem_arr[3]}, 32'h2008_0020);

    cyc(1, $urandom, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) idle_cyc();
    idle_cyc();

    cyc(1, $urandom, 0, 0, 0, 0, 0);
    idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle_cyc();
    idle_cyc();

    for (int i = 0; i < LINE + 1; i++) begin
      do_load($urandom);
      repeat ($urandom_range(0, 2)) idle_cyc();
    end

    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h47, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("redirect_pc_aligned", pc, 32'h44);
    repeat (30) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h200, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h38, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("resume_pc4", if_id_pc4, 32'h40);

    for (int i = 0; i < 400; i++) begin
      logic        rd;
      logic [31:0] tgt;
      rd  = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 9) == 0) ? MEMB + $urandom_range(0, 255) : $urandom_range(0, MEMB - 1);
      cyc(1'($urandom_range(0, 1)), $urandom, 0, ($urandom_range(0, 3) == 0), rd, tgt, 0);
    end

    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle_cyc();
    idle_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
